// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential shift-add multiplier.
// Latency: none (package only).
// Backpressure: none (package only).
package mult_pkg;

   // Controller states: waiting, iterating over multiplier digits, result pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to hold values 0..v-1; never less than one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Even width of at least 4, and a radix of 1, 2 or 4 bits that divides the width.
   function automatic bit legal_cfg(input int w, input int bpc);
      bit ok;
      ok = (w >= 4) && ((w % 2) == 0);
      ok = ok && ((bpc == 1) || (bpc == 2) || (bpc == 4));
      ok = ok && ((w % bpc) == 0);
      return ok;
   endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One shift-add step: acc + (mcand * digit) << (cnt * BITS_PER_CYCLE).
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module mult_pp_step
   import mult_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int CW             = 6
) (
   input  logic [2*WIDTH-1:0]        acc,
   input  logic [WIDTH-1:0]          mcand,
   input  logic [BITS_PER_CYCLE-1:0] slice,
   input  logic [CW-1:0]             cnt,
   output logic [2*WIDTH-1:0]        acc_nxt
);

   logic [2*WIDTH-1:0] ext;
   logic [2*WIDTH-1:0] pp;

   // Digit times multiplicand built from shifted copies, then aligned to the digit position.
   always_comb begin
      ext = {{WIDTH{1'b0}}, mcand};
      pp  = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         if (slice[j]) pp = pp + (ext << j);
      end
      acc_nxt = acc + (pp << (cnt * BITS_PER_CYCLE));
   end

endmodule

// File: rtl/mult_seq.sv
// Sequential signed/unsigned multiplier, BITS_PER_CYCLE multiplier bits per RUN cycle.
// Latency: start edge k -> done after edge k+N+1 (N = WIDTH/BITS_PER_CYCLE); MULT_EARLY_TERM_EN may shorten it.
// Backpressure: busy while iterating; start is ignored until the DONE or IDLE state.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   z
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = clog2(N + 1);

   if (!legal_cfg(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
      $error("mult_seq: illegal WIDTH/BITS_PER_CYCLE combination");
   end

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [CW-1:0]      cnt;
   logic               neg;
   // Set once the last useful digit has been accumulated; the following cycle
   // applies the sign and moves to DONE.
   logic               fin;
   logic               capture;
   logic               step;
   logic               last_step;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
   always_comb begin
      mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
      mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
   end

   // Decide whether the step being taken now retires the final nonzero digit.
   always_comb begin
      last_step = (cnt == CW'(N - 1));
`ifdef MULT_EARLY_TERM_EN
      if ((mplier >> BITS_PER_CYCLE) == '0) last_step = 1'b1;
`endif
   end

   mult_pp_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .CW             (CW)
   ) u_step (
      .acc     (acc),
      .mcand   (mcand),
      .slice   (mplier[BITS_PER_CYCLE-1:0]),
      .cnt     (cnt),
      .acc_nxt (acc_nxt)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      step      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               capture   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (fin) begin
               state_nxt = DONE;
            end else begin
               step = 1'b1;
               busy = 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               capture   = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, per-cycle accumulate, and sign fix-up into z on the way to DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         fin    <= 1'b0;
         z      <= '0;
      end else begin
         if (capture) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            fin    <= 1'b0;
         end else if (step) begin
            acc    <= acc_nxt;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt + CW'(1);
            fin    <= last_step;
         end
         if (state == RUN && fin) begin
            z <= neg ? -acc : acc;
         end
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Directed and swept checks for mult_seq at WIDTH=32 and WIDTH=8 (radix 1/2/4).
// Latency: expectations use N+1 cycles from the start edge, or the early-exit figures.
// Backpressure: start is only driven while the block is IDLE or DONE, except where ignoring it is the point.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] z;

   logic        start8;
   logic        sgn8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [2:0]  busy8;
   logic [2:0]  done8;
   logic [15:0] z8 [3];

   int errors = 0;
   int checks = 0;

`ifdef MULT_EARLY_TERM_EN
   localparam int EARLY_LAT = 2;
`else
   localparam int EARLY_LAT = 33;
`endif

   always #5 clk = ~clk;

   mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .a(a), .b(b), .busy(busy), .done(done), .z(z)
   );

   mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8_1 (
      .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
      .a(a8), .b(b8), .busy(busy8[0]), .done(done8[0]), .z(z8[0])
   );

   mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8_2 (
      .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
      .a(a8), .b(b8), .busy(busy8[1]), .done(done8[1]), .z(z8[1])
   );

   mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut8_4 (
      .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
      .a(a8), .b(b8), .busy(busy8[2]), .done(done8[2]), .z(z8[2])
   );

   function automatic logic [15:0] ref16(input logic [7:0] x, input logic [7:0] y, input logic s);
      logic [15:0] xe;
      logic [15:0] ye;
      xe = s ? {{8{x[7]}}, x} : {8'h00, x};
      ye = s ? {{8{y[7]}}, y} : {8'h00, y};
      return xe * ye;
   endfunction

   // One 32-bit operation from an IDLE/DONE state; lat counts edges after the start edge.
   task automatic do_op32(input logic [31:0] ai, input logic [31:0] bi, input logic s,
                          output logic [63:0] zr, output int lat, output int bcnt, output int ovl);
      @(negedge clk);
      a = ai; b = bi; is_signed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; ovl = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
         if (busy && done) ovl++;
      end
      zr = z;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      #12;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (z !== 64'h0) begin errors++; $display("FAIL reset_z got=%h want=0", z); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_unsigned;
      logic [63:0] zr; int lat, bcnt, ovl;
      do_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL uns_max_z got=%h want=fffffffe00000001", zr); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL uns_max_latency got=%0d want=33", lat); end
      checks++; if (bcnt !== 32) begin errors++; $display("FAIL uns_max_busy_cycles got=%0d want=32", bcnt); end
      checks++; if (ovl !== 0) begin errors++; $display("FAIL busy_done_overlap got=%0d want=0", ovl); end
      do_op32(32'hFFFFFFFD, 32'd7, 1'b0, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'h00000006FFFFFFEB) begin errors++; $display("FAIL uns_m3x7_z got=%h want=00000006ffffffeb", zr); end
   endtask

   task automatic test_signed;
      logic [63:0] zr; int lat, bcnt, ovl;
      do_op32(32'h80000000, 32'h80000000, 1'b1, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'h4000000000000000) begin errors++; $display("FAIL sgn_minmin_z got=%h want=4000000000000000", zr); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL sgn_latency got=%0d want=33", lat); end
      do_op32(32'hFFFFFFFD, 32'd7, 1'b1, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'hFFFFFFFFFFFFFFEB) begin errors++; $display("FAIL sgn_m3x7_z got=%h want=ffffffffffffffeb", zr); end
      do_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'h1) begin errors++; $display("FAIL sgn_m1xm1_z got=%h want=1", zr); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] zr; int lat, bcnt, ovl;
      do_op32(32'd3, 32'd4, 1'b0, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'd12) begin errors++; $display("FAIL b2b_first_z got=%0d want=12", zr); end
      // Still inside the DONE cycle: request the next operation immediately.
      a = 32'd6; b = 32'd7; is_signed = 1'b0; start = 1'b1;
      #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_held got=%b want=1", done); end
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got=%b want=1", busy); end
      repeat (5) begin @(posedge clk); #1; lat++; end
      @(negedge clk);
      a = 32'd100; b = 32'd100; start = 1'b1;
      @(posedge clk); #1;
      lat++;
      start = 1'b0; a = '0; b = '0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_start_busy got=%b want=1", busy); end
      checks++; if (z !== 64'd12) begin errors++; $display("FAIL run_z_held got=%0d want=12", z); end
      while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency got=%0d want=33", lat); end
      checks++; if (z !== 64'd42) begin errors++; $display("FAIL b2b_second_z got=%0d want=42", z); end
   endtask

   task automatic test_reset_mid;
      logic [63:0] zr; int lat, bcnt, ovl; int seen;
      @(negedge clk);
      a = 32'd123; b = 32'd456; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b want=1", busy); end
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
      checks++; if (z !== 64'h0) begin errors++; $display("FAIL mid_reset_z got=%h want=0", z); end
      @(negedge clk); reset = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_done got=%0d want=0", seen); end
      do_op32(32'd5, 32'd5, 1'b0, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'd25) begin errors++; $display("FAIL post_reset_z got=%0d want=25", zr); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL post_reset_latency got=%0d want=33", lat); end
   endtask

   task automatic test_early_term;
      logic [63:0] zr; int lat, bcnt, ovl;
      do_op32(32'd12345, 32'd0, 1'b0, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'd0) begin errors++; $display("FAIL et_b0_z got=%h want=0", zr); end
      checks++; if (lat !== EARLY_LAT) begin errors++; $display("FAIL et_b0_latency got=%0d want=%0d", lat, EARLY_LAT); end
      do_op32(32'd9, 32'd1, 1'b0, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'd9) begin errors++; $display("FAIL et_b1_z got=%h want=9", zr); end
      checks++; if (lat !== EARLY_LAT) begin errors++; $display("FAIL et_b1_latency got=%0d want=%0d", lat, EARLY_LAT); end
      do_op32(32'd1, 32'h80000000, 1'b0, zr, lat, bcnt, ovl);
      checks++; if (zr !== 64'h80000000) begin errors++; $display("FAIL et_msb_z got=%h want=80000000", zr); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL et_msb_latency got=%0d want=33", lat); end
   endtask

   task automatic test_sweep8;
      int lat8 [3];
      logic [15:0] zr8 [3];
      bit got [3];
      int cyc;
      int nexp [3];
      logic [15:0] want;
      nexp[0] = 9; nexp[1] = 5; nexp[2] = 3;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom_range(0, 1));
         // Force a few boundary operands into the mix.
         if (i == 0) begin a8 = 8'h80; b8 = 8'h80; sgn8 = 1'b1; end
         if (i == 1) begin a8 = 8'hFF; b8 = 8'hFF; sgn8 = 1'b0; end
         if (i == 2) begin a8 = 8'h80; b8 = 8'h7F; sgn8 = 1'b1; end
         start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0;
         want = ref16(a8, b8, sgn8);
         cyc = 0;
         for (int j = 0; j < 3; j++) begin got[j] = 1'b0; lat8[j] = 0; zr8[j] = '0; end
         while (!(got[0] && got[1] && got[2]) && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            for (int j = 0; j < 3; j++) begin
               if (!got[j] && done8[j]) begin got[j] = 1'b1; lat8[j] = cyc; zr8[j] = z8[j]; end
            end
         end
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (!got[j] || zr8[j] !== want) begin
               errors++;
               $display("FAIL sweep8_z cfg=%0d a=%h b=%h s=%b got=%h want=%h", j, a8, b8, sgn8, zr8[j], want);
            end
            checks++;
`ifdef MULT_EARLY_TERM_EN
            if (lat8[j] < 2 || lat8[j] > nexp[j]) begin
               errors++;
               $display("FAIL sweep8_latency cfg=%0d got=%0d want=2..%0d", j, lat8[j], nexp[j]);
            end
`else
            if (lat8[j] !== nexp[j]) begin
               errors++;
               $display("FAIL sweep8_latency cfg=%0d got=%0d want=%0d", j, lat8[j], nexp[j]);
            end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_reset_mid();
      test_early_term();
      test_sweep8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
